uart_tx_buffered: RTL and testbench

- Transmit half of the serial link: the processor writes bytes (via the MMIO store path), and this block serialises them onto FPGA_SERIAL_TX as 8N1 frames, LSB first.
- An internal FIFO decouples bursts of CPU stores from the slow line rate.
- Complements the existing receive path that feeds received bytes to writeback; the top-level drives its serial output from this block.

---
 rtl/uart_tx_buffered_pkg.sv | 30 +++
 rtl/sync_fifo.sv | 70 +++++++
 rtl/uart_tx_buffered.sv | 144 ++++++++++++++
 tb/tb_uart_tx_buffered.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_buffered_pkg.sv
// rtl/uart_tx_buffered_pkg.sv - shared FSM encodings and width helpers for the buffered UART transmitter
package uart_tx_buffered_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // A counter must be at least one bit wide even when it only ever holds 0.
    function automatic int cnt_width(input int value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

    function automatic int symbol_cycles(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with a registered push_ready, shared by the transmit and receive paths
module sync_fifo
    import uart_tx_buffered_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    output logic                   push_ready,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [clog2(DEPTH):0]  count
);

    localparam int PTR_W = cnt_width(DEPTH);
    localparam int CNT_W = clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_d;
    logic             push_ok;
    logic             pop_ok;

    // push_ready only reflects state left by the previous edge, so a pop cannot free a slot in the same cycle.
    assign push_ok  = push && push_ready;
    assign pop_ok   = pop && !empty;
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_comb begin
        count_d = count;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count + CNT_W'(1);
            2'b01:   count_d = count - CNT_W'(1);
            default: count_d = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            push_ready <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count      <= count_d;
            push_ready <= (count_d != CNT_W'(DEPTH));
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - FIFO-buffered 8N1 UART transmitter; UART_TX_PARITY_EN adds an even-parity bit (8E1)
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  data_in,
    input  logic                        data_in_valid,
    output logic                        data_in_ready,
    output logic                        serial_out,
    output logic                        busy,
    output logic [clog2(FIFO_DEPTH):0]  fifo_count
);

    localparam int SYMBOL_CYCLES = symbol_cycles(CLOCK_FREQ, BAUD_RATE);
    localparam int CYC_W         = cnt_width(SYMBOL_CYCLES);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(SYMBOL_CYCLES - 1);

    tx_state_t        state_q, state_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             serial_q, serial_d;
    logic             symbol_done;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_data;
`ifdef UART_TX_PARITY_EN
    logic             parity_q;
`endif

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (data_in_valid && !fifo_full),
        .push_data  (data_in),
        .push_ready (data_in_ready),
        .pop        (fifo_pop),
        .pop_data   (fifo_data),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    assign symbol_done = (cyc_q == CYC_LAST);
    assign serial_out  = serial_q;
    assign busy        = (state_q != IDLE) || (fifo_count != '0);

    // serial_d is the level for the state just entered; it reaches the pin one edge later through serial_q.
    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        serial_d = 1'b1;
        if (state_q != IDLE) begin
            cyc_d = symbol_done ? '0 : cyc_q + CYC_W'(1);
        end
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_data;
                    cyc_d    = '0;
                    bit_d    = '0;
                    state_d  = START;
                end
            end
            START: begin
                serial_d = 1'b0;
                if (symbol_done) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                serial_d = shift_q[0];
                if (symbol_done) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                serial_d = parity_q;
                if (symbol_done) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                serial_d = 1'b1;
                if (symbol_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cyc_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            serial_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (fifo_pop) begin
            parity_q <= ^fifo_data;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - self-checking bench for uart_tx_buffered at SYMBOL_CYCLES=10
module tb_uart_tx_buffered;

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * 10 + 1;
    localparam int LIMIT = 3000;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
        logic       par;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_in_valid = 1'b0;
    logic       data_in_ready;
    logic       serial_out;
    logic       busy;
    logic [3:0] fifo_count;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int          glitches = 0;
    int          idle_bad = 0;
    vec_t        vecs [5];

    uart_tx_buffered #(
        .CLOCK_FREQ (100),
        .BAUD_RATE  (10),
        .FIFO_DEPTH (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .serial_out    (serial_out),
        .busy          (busy),
        .fifo_count    (fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(serial_out) begin
        if ($time > 0 && !rst && clk !== 1'b1) glitches++;
    end

    always @(negedge clk) begin
        if (!rst && !busy && serial_out !== 1'b1) idle_bad++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] mkframe(input logic [9:0] f, input logic par);
`ifdef UART_TX_PARITY_EN
        return {1'b1, par, f[8:0]};
`else
        return {par & 1'b0, f};
`endif
    endfunction

    task automatic push_byte(input logic [7:0] b, output int unsigned k);
        int t;
        t = 0;
        data_in = b;
        data_in_valid = 1'b1;
        while (data_in_ready !== 1'b1 && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        if (t >= LIMIT) check("push_ready_timeout", data_in_ready, 1);
        @(negedge clk);
        k = cyc;
        data_in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy !== 1'b0 && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        if (t >= LIMIT) check("idle_timeout", busy, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic expect_line(input logic [10:0] frame, input string tag);
        for (int j = 0; j < NB; j++) begin
            logic act;
            act = frame[j];
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (serial_out !== frame[j]) act = serial_out;
            end
            check($sformatf("%s bit%0d", tag, j), act, frame[j]);
        end
    endtask

    task automatic send_and_check(input logic [7:0] b, input logic [10:0] frame, input string tag);
        int unsigned k;
        push_byte(b, k);
        check({tag, " count_after_push"}, fifo_count, 1);
        check({tag, " busy_after_push"}, busy, 1);
        @(negedge clk);
        check({tag, " line_high_k+1"}, serial_out, 1);
        check({tag, " count_after_pop"}, fifo_count, 0);
        expect_line(frame, tag);
        check({tag, " busy_after_stop"}, busy, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic decode_frame(output logic [7:0] b, output logic p, output int unsigned s);
        int t;
        t = 0;
        b = 8'h00;
        p = 1'b0;
        while (serial_out !== 1'b0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) check("decode_start_timeout", serial_out, 0);
        s = cyc;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (10) @(negedge clk);
            b[i] = serial_out;
        end
`ifdef UART_TX_PARITY_EN
        repeat (10) @(negedge clk);
        p = serial_out;
`endif
        repeat (10) @(negedge clk);
        check("decode_stop_bit", serial_out, 1);
    endtask

    initial begin
        int unsigned ka, kb, ke, kr;
        logic [9:0]  burst_par;

        vecs[0] = '{data: 8'hA5, frame: 10'b1_10100101_0, par: 1'b0};
        vecs[1] = '{data: 8'h07, frame: 10'b1_00000111_0, par: 1'b1};
        vecs[2] = '{data: 8'h03, frame: 10'b1_00000011_0, par: 1'b0};
        vecs[3] = '{data: 8'hFF, frame: 10'b1_11111111_0, par: 1'b0};
        vecs[4] = '{data: 8'h80, frame: 10'b1_10000000_0, par: 1'b1};
        burst_par = 10'b0110010110;

        #2 rst = 1'b1;
        #1;
        check("reset serial_out", serial_out, 1);
        check("reset data_in_ready", data_in_ready, 0);
        check("reset busy", busy, 0);
        check("reset fifo_count", fifo_count, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 check("ready_low_before_edge", data_in_ready, 0);
        @(negedge clk);
        check("ready_after_first_edge", data_in_ready, 1);

        for (int i = 0; i < 5; i++) begin
            send_and_check(vecs[i].data, mkframe(vecs[i].frame, vecs[i].par), $sformatf("vec%0d", i));
        end

        // Burst: 10 bytes back to back; the tenth is held off by a full FIFO.
        wait_idle();
        fork
            begin
                int unsigned k;
                for (int i = 0; i < 10; i++) begin
                    push_byte(8'(i), k);
                    if (i == 8) begin
                        check("burst count_full", fifo_count, 8);
                        check("burst ready_full", data_in_ready, 0);
                    end
                end
            end
            begin
                logic [7:0]  b;
                logic        p;
                int unsigned s, prev;
                prev = 0;
                for (int i = 0; i < 10; i++) begin
                    decode_frame(b, p, s);
                    check($sformatf("burst byte%0d", i), b, 32'(i));
`ifdef UART_TX_PARITY_EN
                    check($sformatf("burst parity%0d", i), p, burst_par[i]);
`endif
                    if (i > 0) check($sformatf("burst spacing%0d", i), s - prev, FRAME);
                    prev = s;
                end
            end
        join

        // Push lands on the same edge as a pop with three bytes buffered.
        wait_idle();
        fork
            begin
                int t;
                push_byte(8'h11, ka);
                push_byte(8'h22, kb);
                push_byte(8'h33, kb);
                push_byte(8'h44, kb);
                check("simul count_before", fifo_count, 3);
                t = 0;
                while (cyc < ka + FRAME && t < LIMIT) begin
                    @(negedge clk);
                    t++;
                end
                check("simul count_at_idle", fifo_count, 3);
                push_byte(8'h55, ke);
                check("simul push_edge", ke, ka + FRAME + 1);
                check("simul count_after", fifo_count, 3);
            end
            begin
                logic [7:0]  b;
                logic        p;
                int unsigned s;
                logic [7:0]  exp_b [5];
                exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
                for (int i = 0; i < 5; i++) begin
                    decode_frame(b, p, s);
                    check($sformatf("simul byte%0d", i), b, exp_b[i]);
                end
            end
        join

        // Reset lands mid-data of 0x3C while two more bytes wait in the FIFO.
        wait_idle();
        push_byte(8'h3C, kr);
        push_byte(8'h55, ka);
        push_byte(8'h66, ka);
        while (cyc < kr + 25) @(negedge clk);
        check("pre_reset serial_bit1", serial_out, 0);
        check("pre_reset count", fifo_count, 2);
        rst = 1'b1;
        #1;
        check("mid_reset serial_out", serial_out, 1);
        check("mid_reset busy", busy, 0);
        check("mid_reset fifo_count", fifo_count, 0);
        check("mid_reset ready", data_in_ready, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 check("post_reset ready_before_edge", data_in_ready, 0);
        @(negedge clk);
        check("post_reset ready", data_in_ready, 1);
        check("post_reset serial", serial_out, 1);
        send_and_check(8'h81, mkframe(10'b1_10000001_0, 1'b0), "after_reset");

        repeat (20) @(negedge clk);
        check("glitch_count", glitches, 0);
        check("idle_line_low_count", idle_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
